// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Loader states, instruction word width and default sizing.
package prog_loader_pkg;

  localparam int unsigned WORD_W        = 16;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_MAX_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/prog_loader_byte_pair_assembler.sv
// Joins a big-endian byte pair into one instruction word and
// pulses word_valid for the cycle after the low byte lands.
module byte_pair_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  // Merge the incoming byte into the proper half of the word
  always_comb begin
    word_d  = word_q;
    valid_d = lo_en;
    if (hi_en) word_d[15:8] = byte_in;
    if (lo_en) word_d[7:0]  = byte_in;
  end

  // Word and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length header + big-endian words into imem, CPU held until done.
// Optional trailing XOR checksum byte: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              imem_wen,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0]   MAX_WC   = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [15:0]       MAX_LEN  = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_WORDS - 1);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e FIN_ST = ST_CHK;
`else
  localparam state_e FIN_ST = ST_DONE;
`endif

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  logic        xfer;
  logic        hi_en;
  logic        lo_en;
  logic [15:0] len_new;
  logic [16:0] wc_next;
  logic        asm_valid;
  logic [WORD_W-1:0] asm_word;

  assign in_ready = (state_q == ST_LEN_HI)
                 || (state_q == ST_LEN_LO)
                 || (state_q == ST_DATA_HI)
                 || (state_q == ST_DATA_LO)
                 || (state_q == ST_CHK);
  assign xfer    = in_valid && in_ready;
  assign hi_en   = xfer && (state_q == ST_DATA_HI);
  assign lo_en   = xfer && (state_q == ST_DATA_LO);
  assign len_new = {len_q[15:8], in_data};
  assign wc_next = 17'(wc_q) + 17'd1;

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst_n      (reset),
    .hi_en      (hi_en),
    .lo_en      (lo_en),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // Next-state, length capture, word counting and status flags
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wc_d    = wc_q;
    err_d   = err_q;
    done_d  = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) done_d = !err_q;
        if (start) begin
          state_d = ST_LEN_HI;
          len_d   = '0;
          wc_d    = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = FIN_ST;
          end else if (len_new > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          state_d = ST_DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ in_data;
`endif
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          state_d = ST_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ in_data;
`endif
        end
      end
      ST_WRITE: begin
        if (wc_q != MAX_WC) wc_d = wc_next[ADDR_W:0];
        if (wc_next < {1'b0, len_q}) state_d = ST_DATA_HI;
        else                         state_d = FIN_ST;
      end
      ST_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (xfer) begin
          if (in_data != chk_q) err_d = 1'b1;
          state_d = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR of the data bytes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chk_q <= '0;
    else        chk_q <= chk_d;
  end
`endif

  assign imem_wen   = asm_valid;
  assign imem_wdata = asm_word;
  assign imem_addr  = (wc_q >= MAX_WC) ? MAX_ADDR
                                       : wc_q[ADDR_W-1:0];
  assign done       = done_q;
  assign cpu_hold   = !done_q;
  assign error      = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader.
// Reference model derives writes and status from the byte stream.
module tb_prog_loader;

  localparam int AW = 8;
  localparam int MW = 256;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          imem_wen;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  wr_cnt = 0;
  wr_t sb[$];

  prog_loader #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_wen   (imem_wen),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, int unsigned act,
                                int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every write strobe pops the next expected write
  always @(negedge clk) begin : mon
    wr_t e;
    if (reset === 1'b1 && imem_wen === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h@%0h expected none",
                 imem_wdata, imem_addr);
      end else begin
        e = sb.pop_front();
        check("wr_addr", imem_addr, e.a);
        check("wr_data", imem_wdata, e.d);
      end
      check("ready_in_write", in_ready, 0);
    end
  end

  function automatic bq_t add_chk(bq_t q, bit bad);
    bq_t r = q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 2; i < q.size(); i++) x ^= q[i];
    r.push_back(bad ? ~x : x);
`else
    if (bad) r = q;
`endif
    return r;
  endfunction

  function automatic bq_t mk(int len, bit bad);
    bq_t q;
    logic [15:0] l = 16'(len);
    q.push_back(l[15:8]);
    q.push_back(l[7:0]);
    if (len > MW) return q;
    for (int i = 0; i < 2 * len; i++)
      q.push_back(8'($urandom_range(0, 255)));
    return add_chk(q, bad);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, bit rnd);
    int t = 0;
    forever begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = b;
      if (in_valid && in_ready) begin
        @(posedge clk);
        break;
      end
      t++;
      if (t > 500) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        break;
      end
    end
  endtask

  // Load one stream and compare status against the reference model
  task automatic run_load(bq_t bs, bit rnd, string tag);
    int unsigned len;
    bit          err;
    int unsigned wc;
    int          t = 0;
    len = {bs[0], bs[1]};
    err = 0;
    wc  = 0;
    if (len > MW) begin
      err = 1;
    end else begin
      for (int i = 0; i < len; i++)
        sb.push_back({AW'(i), bs[2 + 2 * i], bs[3 + 2 * i]});
      wc = len;
`ifdef PROG_LOADER_CHECKSUM_EN
      begin
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 2 * len; i++) x ^= bs[2 + i];
        if (x != bs[2 + 2 * len]) err = 1;
      end
`endif
    end
    pulse_start();
    foreach (bs[i]) send_byte(bs[i], rnd);
    @(negedge clk);
    in_valid = 1'b0;
    while (!(done || error) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_end_timeout: got no done/error", tag);
    end
    @(negedge clk);
    check({tag, "_done"}, done, !err);
    check({tag, "_error"}, error, err);
    check({tag, "_hold"}, cpu_hold, err);
    check({tag, "_wc"}, word_count, wc);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin : main
    bq_t s;
    int  w0;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_wen", imem_wen, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wc", word_count, 0);
    reset = 1'b1;
    @(negedge clk);

    s = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_load(add_chk(s, 0), 0, "basic");

    // Zero length: done exactly two cycles after the final transfer
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    check("zero_done_early", done, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_hold", cpu_hold, 0);
    check("zero_wc", word_count, 0);

    s = {8'h01, 8'h01};
    run_load(s, 0, "len257");
    repeat (3) @(negedge clk);
    check("len257_done_stays", done, 0);
    check("len257_hold_stays", cpu_hold, 1);

    s = mk(4, 0);
    run_load(s, 0, "b2b4");
    run_load(s, 1, "rnd4");

    // Reset after the third word of a five-word load
    s  = mk(5, 0);
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++)
      sb.push_back({AW'(i), s[2 + 2 * i], s[3 + 2 * i]});
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(s[i], 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_writes", wr_cnt - w0, 3);
    #2 reset = 1'b0;
    #1;
    check("mid_ready", in_ready, 0);
    check("mid_wen", imem_wen, 0);
    check("mid_addr", imem_addr, 0);
    check("mid_wdata", imem_wdata, 0);
    check("mid_hold", cpu_hold, 1);
    check("mid_done", done, 0);
    check("mid_error", error, 0);
    check("mid_wc", word_count, 0);
    @(negedge clk);
    reset = 1'b1;
    run_load(s, 1, "after_rst");

`ifdef PROG_LOADER_CHECKSUM_EN
    s = mk(3, 1);
    run_load(s, 1, "bad_chk");
    s = mk(3, 0);
    run_load(s, 1, "good_chk");
`endif

    for (int k = 0; k < 6; k++) begin
      s = mk($urandom_range(1, 8), 0);
      run_load(s, 1, "rand");
    end
    s = mk($urandom_range(MW + 1, 65535), 0);
    run_load(s, 1, "rand_big");
    s = mk(MW, 0);
    run_load(s, 0, "max");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
